// File: rtl/sargantana_icache_mshr.sv
// Instruction-cache miss status holding registers: tracks outstanding line fills,
// merges repeat misses, optionally prefetches the next line, and writes completed lines.
module sargantana_icache_mshr #(
   parameter int unsigned N_ENTRIES   = 2,
   parameter int unsigned LADDR_W     = 26,
   parameter int unsigned WAY_W       = 2,
   parameter int unsigned BEAT_W      = 64,
   parameter int unsigned BEATS       = 2,
   parameter int unsigned PREFETCH_EN = 0
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               miss_valid_i,
   input  logic [LADDR_W-1:0]                 miss_laddr_i,
   input  logic [WAY_W-1:0]                   miss_way_i,
   output logic                               miss_ready_o,
   input  logic                               kill_i,
   output logic                               ifill_req_valid_o,
   input  logic                               ifill_req_ready_i,
   output logic [LADDR_W-1:0]                 ifill_req_laddr_o,
   output logic [$clog2(N_ENTRIES)-1:0]       ifill_req_id_o,
   input  logic                               ifill_resp_valid_i,
   input  logic [$clog2(N_ENTRIES)-1:0]       ifill_resp_id_i,
   input  logic [BEAT_W-1:0]                  ifill_resp_data_i,
   input  logic                               ifill_resp_last_i,
   output logic                               wr_valid_o,
   input  logic                               wr_ready_i,
   output logic [LADDR_W-1:0]                 wr_laddr_o,
   output logic [WAY_W-1:0]                   wr_way_o,
   output logic [BEATS*BEAT_W-1:0]            wr_data_o,
   output logic                               merge_o,
   output logic                               full_o,
   output logic                               busy_o,
   output logic                               err_o
);

   localparam int unsigned ID_W   = $clog2(N_ENTRIES);
   localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned LINE_W = BEATS * BEAT_W;

   localparam logic [1:0] ST_FREE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;
   localparam logic [1:0] ST_WRITE = 2'd3;

   logic [1:0]         state_q  [N_ENTRIES];
   logic [1:0]         state_d  [N_ENTRIES];
   logic [LADDR_W-1:0] laddr_q  [N_ENTRIES];
   logic [LADDR_W-1:0] laddr_d  [N_ENTRIES];
   logic [WAY_W-1:0]   way_q    [N_ENTRIES];
   logic [WAY_W-1:0]   way_d    [N_ENTRIES];
   logic [CNT_W-1:0]   cnt_q    [N_ENTRIES];
   logic [CNT_W-1:0]   cnt_d    [N_ENTRIES];
   logic [LINE_W-1:0]  line_q   [N_ENTRIES];
   logic [LINE_W-1:0]  line_d   [N_ENTRIES];
   logic [N_ENTRIES-1:0] killed_q, killed_d;
   logic                 err_q, err_d;

   logic [N_ENTRIES-1:0] free_vec, live_vec, hit_vec, pf_hit_vec, req_vec, wr_vec;
   logic [ID_W-1:0]      alloc_idx, pf_idx, req_idx, wr_idx;
   logic                 pf_found, hit, alloc, pf_alloc, req_fire, wr_fire;
   logic [LADDR_W-1:0]   pf_laddr;

   assign pf_laddr = miss_laddr_i + LADDR_W'(1);

   // Entry lookups; a same-cycle kill already hides REQ/RESP entries from merging.
   always_comb begin : lookup
      free_vec   = '0;
      live_vec   = '0;
      hit_vec    = '0;
      pf_hit_vec = '0;
      req_vec    = '0;
      wr_vec     = '0;
      alloc_idx  = '0;
      pf_idx     = '0;
      req_idx    = '0;
      wr_idx     = '0;
      pf_found   = 1'b0;
      for (int i = 0; i < int'(N_ENTRIES); i++) begin
         free_vec[i]   = (state_q[i] == ST_FREE);
         live_vec[i]   = !free_vec[i] && !killed_q[i] &&
                         !(kill_i && (state_q[i] == ST_REQ || state_q[i] == ST_RESP));
         hit_vec[i]    = live_vec[i] && (laddr_q[i] == miss_laddr_i);
         pf_hit_vec[i] = live_vec[i] && (laddr_q[i] == pf_laddr);
         req_vec[i]    = (state_q[i] == ST_REQ);
         wr_vec[i]     = (state_q[i] == ST_WRITE) && !killed_q[i];
      end
      for (int i = int'(N_ENTRIES) - 1; i >= 0; i--) begin
         if (free_vec[i]) alloc_idx = ID_W'(i);
         if (req_vec[i])  req_idx   = ID_W'(i);
         if (wr_vec[i])   wr_idx    = ID_W'(i);
      end
      for (int i = int'(N_ENTRIES) - 1; i >= 0; i--) begin
         if (free_vec[i] && (ID_W'(i) != alloc_idx)) begin
            pf_idx   = ID_W'(i);
            pf_found = 1'b1;
         end
      end
   end

   assign hit               = |hit_vec;
   assign miss_ready_o      = (|free_vec) | hit;
   assign merge_o           = miss_valid_i & hit;
   assign full_o            = ~(|free_vec);
   assign busy_o            = ~(&free_vec);
   assign err_o             = err_q;
   assign ifill_req_valid_o = |req_vec;
   assign ifill_req_id_o    = req_idx;
   assign ifill_req_laddr_o = laddr_q[req_idx];
   assign wr_valid_o        = |wr_vec;
   assign wr_laddr_o        = laddr_q[wr_idx];
   assign wr_way_o          = way_q[wr_idx];
   assign wr_data_o         = line_q[wr_idx];

   assign alloc    = miss_valid_i & ~hit & (|free_vec);
   assign pf_alloc = (PREFETCH_EN != 0) & alloc & pf_found & ~(|pf_hit_vec);
   assign req_fire = ifill_req_valid_o & ifill_req_ready_i;
   assign wr_fire  = wr_valid_o & wr_ready_i;

   // Next-state: kill, request handshake, beat capture, write retire, then allocation.
   always_comb begin : next_state
      state_d  = state_q;
      laddr_d  = laddr_q;
      way_d    = way_q;
      cnt_d    = cnt_q;
      line_d   = line_q;
      killed_d = killed_q;
      err_d    = err_q;

      if (kill_i) begin
         for (int i = 0; i < int'(N_ENTRIES); i++) begin
            if (state_q[i] == ST_REQ)  state_d[i]  = ST_FREE;
            if (state_q[i] == ST_RESP) killed_d[i] = 1'b1;
         end
      end

      // A request accepted under kill still gets beats back, so it drains as killed.
      if (req_fire) begin
         state_d[req_idx]  = ST_RESP;
         cnt_d[req_idx]    = '0;
         killed_d[req_idx] = kill_i;
      end

      if (ifill_resp_valid_i) begin
         if (state_q[ifill_resp_id_i] != ST_RESP ||
             (ifill_resp_last_i && cnt_q[ifill_resp_id_i] != CNT_W'(BEATS - 1))) begin
            err_d = 1'b1;
         end else begin
            for (int b = 0; b < int'(BEATS); b++) begin
               if (cnt_q[ifill_resp_id_i] == CNT_W'(b))
                  line_d[ifill_resp_id_i][b*BEAT_W +: BEAT_W] = ifill_resp_data_i;
            end
            cnt_d[ifill_resp_id_i] = (cnt_q[ifill_resp_id_i] == CNT_W'(BEATS - 1)) ?
                                     '0 : cnt_q[ifill_resp_id_i] + CNT_W'(1);
            if (ifill_resp_last_i) state_d[ifill_resp_id_i] = ST_WRITE;
         end
      end

      for (int i = 0; i < int'(N_ENTRIES); i++) begin
         if (state_q[i] == ST_WRITE && killed_q[i]) begin
            state_d[i]  = ST_FREE;
            killed_d[i] = 1'b0;
         end
      end
      if (wr_fire) state_d[wr_idx] = ST_FREE;

      if (alloc) begin
         state_d[alloc_idx]  = ST_REQ;
         laddr_d[alloc_idx]  = miss_laddr_i;
         way_d[alloc_idx]    = miss_way_i;
         cnt_d[alloc_idx]    = '0;
         killed_d[alloc_idx] = 1'b0;
      end
      if (pf_alloc) begin
         state_d[pf_idx]  = ST_REQ;
         laddr_d[pf_idx]  = pf_laddr;
         way_d[pf_idx]    = miss_way_i;
         cnt_d[pf_idx]    = '0;
         killed_d[pf_idx] = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin : state_reg
      if (rst_i) begin
         for (int i = 0; i < int'(N_ENTRIES); i++) begin
            state_q[i] <= ST_FREE;
            laddr_q[i] <= '0;
            way_q[i]   <= '0;
            cnt_q[i]   <= '0;
            line_q[i]  <= '0;
         end
         killed_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         laddr_q  <= laddr_d;
         way_q    <= way_d;
         cnt_q    <= cnt_d;
         line_q   <= line_d;
         killed_q <= killed_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_sargantana_icache_mshr.sv
// Bench for sargantana_icache_mshr: directed scenarios plus a randomized run
// against a slot-level reference model (default instance and a prefetch instance).
module tb_sargantana_icache_mshr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         miss_valid;
   logic [25:0]  miss_laddr;
   logic [1:0]   miss_way;
   logic         kill;
   logic         ifill_req_ready;
   logic         resp_valid;
   logic         resp_id;
   logic [63:0]  resp_data;
   logic         resp_last;
   logic         wr_ready;

   logic         miss_ready, req_valid, req_id, wr_valid, merge, full, busy, err;
   logic [25:0]  req_laddr, wr_laddr;
   logic [1:0]   wr_way;
   logic [127:0] wr_data;

   logic         pf_miss_ready, pf_req_valid, pf_req_id, pf_wr_valid, pf_merge, pf_full, pf_busy, pf_err;
   logic [25:0]  pf_req_laddr, pf_wr_laddr;
   logic [1:0]   pf_wr_way;
   logic [127:0] pf_wr_data;

   sargantana_icache_mshr u_dut (
      .clk_i(clk), .rst_i(rst),
      .miss_valid_i(miss_valid), .miss_laddr_i(miss_laddr), .miss_way_i(miss_way),
      .miss_ready_o(miss_ready), .kill_i(kill),
      .ifill_req_valid_o(req_valid), .ifill_req_ready_i(ifill_req_ready),
      .ifill_req_laddr_o(req_laddr), .ifill_req_id_o(req_id),
      .ifill_resp_valid_i(resp_valid), .ifill_resp_id_i(resp_id),
      .ifill_resp_data_i(resp_data), .ifill_resp_last_i(resp_last),
      .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_laddr_o(wr_laddr),
      .wr_way_o(wr_way), .wr_data_o(wr_data),
      .merge_o(merge), .full_o(full), .busy_o(busy), .err_o(err)
   );

   sargantana_icache_mshr #(.PREFETCH_EN(1)) u_pf (
      .clk_i(clk), .rst_i(rst),
      .miss_valid_i(miss_valid), .miss_laddr_i(miss_laddr), .miss_way_i(miss_way),
      .miss_ready_o(pf_miss_ready), .kill_i(kill),
      .ifill_req_valid_o(pf_req_valid), .ifill_req_ready_i(ifill_req_ready),
      .ifill_req_laddr_o(pf_req_laddr), .ifill_req_id_o(pf_req_id),
      .ifill_resp_valid_i(resp_valid), .ifill_resp_id_i(resp_id),
      .ifill_resp_data_i(resp_data), .ifill_resp_last_i(resp_last),
      .wr_valid_o(pf_wr_valid), .wr_ready_i(wr_ready), .wr_laddr_o(pf_wr_laddr),
      .wr_way_o(pf_wr_way), .wr_data_o(pf_wr_data),
      .merge_o(pf_merge), .full_o(pf_full), .busy_o(pf_busy), .err_o(pf_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      miss_valid = 1'b0; kill = 1'b0; ifill_req_ready = 1'b0;
      resp_valid = 1'b0; resp_last = 1'b0; wr_ready = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      chk1({tag, "_ready"}, miss_ready, 1'b1);
      chk1({tag, "_full"},  full,       1'b0);
      chk1({tag, "_busy"},  busy,       1'b0);
      chk1({tag, "_reqv"},  req_valid,  1'b0);
      chk1({tag, "_wrv"},   wr_valid,   1'b0);
      chk1({tag, "_merge"}, merge,      1'b0);
      chk1({tag, "_err"},   err,        1'b0);
   endtask

   task automatic do_reset;
      idle();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   // Reference model: one record per entry slot, driven by handshakes seen on the ports.
   typedef struct packed {
      int           phase;   // 0 idle, 1 awaiting request, 2 awaiting beats, 3 awaiting write
      logic [25:0]  laddr;
      logic [1:0]   way;
      logic [127:0] line;
   } slot_t;

   slot_t slot [2];
   int    rq[$];
   int    beat_no;

   localparam logic [63:0] B0 = 64'h0123_4567_89ab_cdef;
   localparam logic [63:0] B1 = 64'hfedc_ba98_7654_3210;

   initial begin
      int  nfree, efree, ereq, ewr, rid;
      logic hit;

      // Reset values on both instances
      idle();
      rst = 1'b1; miss_laddr = '0; miss_way = '0; resp_id = 1'b0; resp_data = '0;
      @(negedge clk);
      reset_checks("rst");
      chk1("rst_pf_ready", pf_miss_ready, 1'b1);
      chk1("rst_pf_busy",  pf_busy,       1'b0);
      cyc();
      rst = 1'b0;

      // Single miss through fill and write
      miss_valid = 1'b1; miss_laddr = 26'h100; miss_way = 2'd1;
      @(negedge clk);
      chk1("basic_ready", miss_ready, 1'b1);
      chk1("basic_merge", merge, 1'b0);
      chk1("basic_req_early", req_valid, 1'b0);
      cyc(); miss_valid = 1'b0; ifill_req_ready = 1'b1;
      @(negedge clk);
      chk1("basic_reqv", req_valid, 1'b1);
      chk1("basic_req_id", req_id, 1'b0);
      chkw("basic_req_laddr", 128'(req_laddr), 128'(26'h100));
      cyc(); ifill_req_ready = 1'b0;
      resp_valid = 1'b1; resp_id = 1'b0; resp_data = B0; resp_last = 1'b0;
      @(negedge clk);
      chk1("basic_wr_b0", wr_valid, 1'b0);
      cyc(); resp_data = B1; resp_last = 1'b1;
      @(negedge clk);
      chk1("basic_wr_early", wr_valid, 1'b0);
      cyc(); resp_valid = 1'b0; resp_last = 1'b0; wr_ready = 1'b1;
      @(negedge clk);
      chk1("basic_wrv", wr_valid, 1'b1);
      chkw("basic_wr_laddr", 128'(wr_laddr), 128'(26'h100));
      chkw("basic_wr_way", 128'(wr_way), 128'(2'd1));
      chkw("basic_wr_data", wr_data, {B1, B0});
      cyc(); wr_ready = 1'b0;
      @(negedge clk);
      chk1("basic_wr_done", wr_valid, 1'b0);
      chk1("basic_idle", busy, 1'b0);
      chk1("basic_err", err, 1'b0);

      // Full, stall, merge
      cyc(); miss_valid = 1'b1; miss_laddr = 26'h10; miss_way = 2'd0;
      @(negedge clk);
      chk1("full_a_ready", miss_ready, 1'b1);
      cyc(); miss_laddr = 26'h20;
      @(negedge clk);
      chk1("full_b_ready", miss_ready, 1'b1);
      chk1("full_b_full", full, 1'b0);
      chk1("full_b_merge", merge, 1'b0);
      cyc(); miss_laddr = 26'h30;
      @(negedge clk);
      chk1("full_full", full, 1'b1);
      chk1("full_stall", miss_ready, 1'b0);
      cyc(); miss_laddr = 26'h10;
      @(negedge clk);
      chk1("full_merge_ready", miss_ready, 1'b1);
      chk1("full_merge", merge, 1'b1);
      cyc(); miss_valid = 1'b0; kill = 1'b1;
      cyc(); kill = 1'b0;
      @(negedge clk);
      chk1("full_kill_idle", busy, 1'b0);

      // Kill during RESP: drain beats, no write; new miss does not merge with killed line
      cyc(); miss_valid = 1'b1; miss_laddr = 26'h200; miss_way = 2'd3;
      cyc(); miss_valid = 1'b0; ifill_req_ready = 1'b1;
      @(negedge clk);
      chk1("kill_reqv", req_valid, 1'b1);
      cyc(); ifill_req_ready = 1'b0; kill = 1'b1;
      miss_valid = 1'b1; miss_laddr = 26'h200; miss_way = 2'd0;
      @(negedge clk);
      chk1("kill_no_merge", merge, 1'b0);
      chk1("kill_ready", miss_ready, 1'b1);
      cyc(); kill = 1'b0; miss_valid = 1'b0;
      resp_valid = 1'b1; resp_id = 1'b0; resp_data = B0; resp_last = 1'b0;
      @(negedge clk);
      chk1("kill_new_reqv", req_valid, 1'b1);
      chk1("kill_new_id", req_id, 1'b1);
      chkw("kill_new_laddr", 128'(req_laddr), 128'(26'h200));
      chk1("kill_wr_a", wr_valid, 1'b0);
      cyc(); resp_data = B1; resp_last = 1'b1;
      @(negedge clk);
      chk1("kill_wr_b", wr_valid, 1'b0);
      cyc(); resp_valid = 1'b0; resp_last = 1'b0;
      @(negedge clk);
      chk1("kill_wr_c", wr_valid, 1'b0);
      chk1("kill_busy", busy, 1'b1);
      cyc(); kill = 1'b1;
      @(negedge clk);
      chk1("kill_wr_d", wr_valid, 1'b0);
      cyc(); kill = 1'b0;
      @(negedge clk);
      chk1("kill_idle", busy, 1'b0);
      chk1("kill_err", err, 1'b0);

      // Beat for a FREE id sets sticky error
      cyc(); resp_valid = 1'b1; resp_id = 1'b1; resp_data = B0;
      cyc(); resp_valid = 1'b0;
      @(negedge clk);
      chk1("err_free_id", err, 1'b1);
      cyc(); cyc();
      @(negedge clk);
      chk1("err_sticky", err, 1'b1);
      cyc(); rst = 1'b1;
      @(negedge clk);
      chk1("err_cleared", err, 1'b0);
      cyc(); rst = 1'b0;

      // Last on beat 0 is an error and is dropped
      miss_valid = 1'b1; miss_laddr = 26'h300; miss_way = 2'd0;
      cyc(); miss_valid = 1'b0; ifill_req_ready = 1'b1;
      cyc(); ifill_req_ready = 1'b0;
      resp_valid = 1'b1; resp_id = 1'b0; resp_data = B0; resp_last = 1'b1;
      cyc(); resp_valid = 1'b0; resp_last = 1'b0;
      @(negedge clk);
      chk1("err_early_last", err, 1'b1);
      chk1("err_early_wr", wr_valid, 1'b0);
      cyc();
      @(negedge clk);
      chk1("err_dropped_wr", wr_valid, 1'b0);
      chk1("err_dropped_busy", busy, 1'b1);

      // Reset mid-fill, then a stale beat
      cyc(); rst = 1'b1;
      @(negedge clk);
      reset_checks("midrst");
      cyc(); rst = 1'b0;
      resp_valid = 1'b1; resp_id = 1'b0; resp_data = B1;
      cyc(); resp_valid = 1'b0;
      @(negedge clk);
      chk1("stale_err", err, 1'b1);

      // Next-line prefetch with address wrap
      cyc(); do_reset();
      miss_valid = 1'b1; miss_laddr = 26'h3FF_FFFF; miss_way = 2'd2;
      @(negedge clk);
      chk1("pf_ready", pf_miss_ready, 1'b1);
      cyc(); miss_valid = 1'b0; ifill_req_ready = 1'b1;
      @(negedge clk);
      chk1("pf_reqv0", pf_req_valid, 1'b1);
      chk1("pf_id0", pf_req_id, 1'b0);
      chkw("pf_laddr0", 128'(pf_req_laddr), 128'(26'h3FF_FFFF));
      chk1("pf_full", pf_full, 1'b1);
      cyc();
      @(negedge clk);
      chk1("pf_reqv1", pf_req_valid, 1'b1);
      chk1("pf_id1", pf_req_id, 1'b1);
      chkw("pf_laddr1", 128'(pf_req_laddr), 128'(26'h0));
      cyc(); do_reset();

      // Randomized traffic against the slot model (default instance)
      for (int i = 0; i < 2; i++) slot[i] = '0;
      rq.delete();
      beat_no = 0;
      for (int n = 0; n < 1500; n++) begin
         miss_valid      = 1'($urandom_range(0, 1));
         miss_laddr      = 26'h40 + 26'($urandom_range(0, 3));
         miss_way        = 2'($urandom_range(0, 3));
         ifill_req_ready = ($urandom_range(0, 2) != 0);
         wr_ready        = ($urandom_range(0, 2) != 0);
         if (rq.size() > 0 && $urandom_range(0, 3) != 0) begin
            resp_valid = 1'b1;
            resp_id    = 1'(rq[0]);
            resp_data  = {$urandom, $urandom};
            resp_last  = (beat_no == 1);
         end else begin
            resp_valid = 1'b0;
            resp_last  = 1'b0;
         end
         @(negedge clk);
         nfree = 0; efree = -1; ereq = -1; ewr = -1; hit = 1'b0;
         for (int s = 1; s >= 0; s--) begin
            if (slot[s].phase == 0) begin
               nfree++;
               efree = s;
            end else if (slot[s].laddr == miss_laddr) begin
               hit = 1'b1;
            end
            if (slot[s].phase == 1) ereq = s;
            if (slot[s].phase == 3) ewr = s;
         end
         chk1("rnd_ready", miss_ready, (nfree > 0) || hit);
         chk1("rnd_merge", merge, miss_valid && hit);
         chk1("rnd_full",  full, nfree == 0);
         chk1("rnd_busy",  busy, nfree < 2);
         chk1("rnd_reqv",  req_valid, ereq >= 0);
         chk1("rnd_wrv",   wr_valid, ewr >= 0);
         chk1("rnd_err",   err, 1'b0);
         if (ereq >= 0) begin
            chk1("rnd_req_id", req_id, 1'(ereq));
            chkw("rnd_req_laddr", 128'(req_laddr), 128'(slot[ereq].laddr));
         end
         if (ewr >= 0) begin
            chkw("rnd_wr_laddr", 128'(wr_laddr), 128'(slot[ewr].laddr));
            chkw("rnd_wr_way", 128'(wr_way), 128'(slot[ewr].way));
            chkw("rnd_wr_data", wr_data, slot[ewr].line);
         end
         // advance the model by what the coming edge will commit
         if (resp_valid) begin
            rid = rq[0];
            slot[rid].line[beat_no*64 +: 64] = resp_data;
            if (resp_last) begin
               slot[rid].phase = 3;
               void'(rq.pop_front());
               beat_no = 0;
            end else begin
               beat_no++;
            end
         end
         if (ereq >= 0 && ifill_req_ready) begin
            slot[ereq].phase = 2;
            rq.push_back(ereq);
         end
         if (ewr >= 0 && wr_ready) slot[ewr].phase = 0;
         if (miss_valid && !hit && nfree > 0) begin
            slot[efree].phase = 1;
            slot[efree].laddr = miss_laddr;
            slot[efree].way   = miss_way;
            slot[efree].line  = '0;
         end
         cyc();
      end

      idle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
